// File: rtl/exc_commit_ctrl.sv
// Exception commit stage: selects the oldest exception of the dual-issue MEM pair, registers
// the CP0 bundle, pulses flush and redirects fetch. Optional macro CP0_BYPASS_EN forwards a same-cycle mtc0.
module exc_commit_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [31:0] EXC_OFFSET = 32'h0000_0180,
  parameter logic [4:0]  ERET_CODE  = 5'h0e
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot1_valid_i,
  input  logic              slot2_valid_i,
  input  logic [8:0]        slot1_exc_i,
  input  logic [8:0]        slot2_exc_i,
  input  logic [ADDR_W-1:0] inst1_addr_i,
  input  logic [ADDR_W-1:0] inst2_addr_i,
  input  logic              is_in_delayslot1_i,
  input  logic              is_in_delayslot2_i,
  input  logic [ADDR_W-1:0] mem_addr1_i,
  input  logic [ADDR_W-1:0] mem_addr2_i,
  input  logic [31:0]       status_i,
  input  logic [31:0]       cause_i,
  input  logic [31:0]       epc_i,
  input  logic [31:0]       ebase_i,
  input  logic              redirect_ready_i,
`ifdef CP0_BYPASS_EN
  input  logic              cp0_we_i,
  input  logic [4:0]        cp0_waddr_i,
  input  logic [31:0]       cp0_wdata_i,
`endif
  output logic              exception_flag_o,
  output logic [4:0]        exception_type_o,
  output logic              exception_first_inst_o,
  output logic [ADDR_W-1:0] inst1_addr_o,
  output logic [ADDR_W-1:0] inst2_addr_o,
  output logic              is_in_delayslot1_o,
  output logic              is_in_delayslot2_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              dbg_state_o
);

  // Bit positions inside slotN_exc_i = {eret,tr,ov,ri,bp,sys,ades,adel_mem,adel_if}
  localparam int B_ADEL_IF  = 0;
  localparam int B_ADEL_MEM = 1;
  localparam int B_ADES     = 2;
  localparam int B_SYS      = 3;
  localparam int B_BP       = 4;
  localparam int B_RI       = 5;
  localparam int B_OV       = 6;
  localparam int B_TR       = 7;
  localparam int B_ERET     = 8;

  localparam logic [4:0] C_INT  = 5'd0;
  localparam logic [4:0] C_ADEL = 5'd4;
  localparam logic [4:0] C_ADES = 5'd5;
  localparam logic [4:0] C_SYS  = 5'd8;
  localparam logic [4:0] C_BP   = 5'd9;
  localparam logic [4:0] C_RI   = 5'd10;
  localparam logic [4:0] C_OV   = 5'd12;
  localparam logic [4:0] C_TR   = 5'd13;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]       w_status;
  logic [31:0]       w_cause;
  logic [31:0]       w_epc;
  logic              w_intr;
  logic              w_slot1_hit;
  logic              w_slot2_hit;
  logic              w_take;
  logic [4:0]        w_code;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [ADDR_W-1:0] w_target;
  logic              w_redirect_valid;
  logic              w_unused;

  logic              r_flag;
  logic [4:0]        r_type;
  logic              r_first;
  logic [ADDR_W-1:0] r_inst1_addr;
  logic [ADDR_W-1:0] r_inst2_addr;
  logic              r_ds1;
  logic              r_ds2;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_redirect_pc;

`ifdef CP0_BYPASS_EN
  assign w_status = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
  assign w_cause  = (cp0_we_i && cp0_waddr_i == 5'd13) ? cp0_wdata_i : cause_i;
  assign w_epc    = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
`else
  assign w_status = status_i;
  assign w_cause  = cause_i;
  assign w_epc    = epc_i;
`endif

  assign w_unused = ^{w_status[31:16], w_status[7:2], w_cause[31:16], w_cause[7:0]};

  // Highest-priority exception code of one slot; an interrupt outranks everything.
  function automatic logic [4:0] f_exc_code(input logic [8:0] exc, input logic intr);
    logic [4:0] code;
    if (intr)                   code = C_INT;
    else if (exc[B_ADEL_IF])    code = C_ADEL;
    else if (exc[B_RI])         code = C_RI;
    else if (exc[B_OV])         code = C_OV;
    else if (exc[B_TR])         code = C_TR;
    else if (exc[B_SYS])        code = C_SYS;
    else if (exc[B_BP])         code = C_BP;
    else if (exc[B_ADEL_MEM])   code = C_ADEL;
    else if (exc[B_ADES])       code = C_ADES;
    else                        code = ERET_CODE;
    return code;
  endfunction

  assign w_intr      = w_status[0] & ~w_status[1] & (|(w_status[15:8] & w_cause[15:8]));
  assign w_slot1_hit = slot1_valid_i & (w_intr | (|slot1_exc_i));
  assign w_slot2_hit = slot2_valid_i & (|slot2_exc_i);
  assign w_take      = (r_state == S_IDLE) & (w_slot1_hit | w_slot2_hit);

  assign w_code      = w_slot1_hit ? f_exc_code(slot1_exc_i, w_intr)
                                   : f_exc_code(slot2_exc_i, 1'b0);
  assign w_mem_addr  = w_slot1_hit ? mem_addr1_i : mem_addr2_i;
  assign w_target    = (w_code == ERET_CODE) ? ADDR_W'(w_epc)
                                             : ADDR_W'(ebase_i) + ADDR_W'(EXC_OFFSET);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Handshake: redirect_valid_o rises with the exception pulse and holds redirect_pc_o stable
  // until a cycle with redirect_ready_i=1; that cycle completes the transfer.
  always_comb begin
    w_state_nxt      = r_state;
    w_redirect_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        w_redirect_valid = 1'b1;
        if (redirect_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flag        <= 1'b0;
      r_type        <= '0;
      r_first       <= 1'b0;
      r_inst1_addr  <= '0;
      r_inst2_addr  <= '0;
      r_ds1         <= 1'b0;
      r_ds2         <= 1'b0;
      r_mem_addr    <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_flag <= w_take;
      if (w_take) begin
        r_type        <= w_code;
        r_first       <= w_slot1_hit;
        r_inst1_addr  <= inst1_addr_i;
        r_inst2_addr  <= inst2_addr_i;
        r_ds1         <= is_in_delayslot1_i;
        r_ds2         <= is_in_delayslot2_i;
        r_mem_addr    <= w_mem_addr;
        r_redirect_pc <= w_target;
      end
    end
  end

  assign exception_flag_o       = r_flag;
  assign flush_o                = r_flag;
  assign exception_type_o       = r_type;
  assign exception_first_inst_o = r_first;
  assign inst1_addr_o           = r_inst1_addr;
  assign inst2_addr_o           = r_inst2_addr;
  assign is_in_delayslot1_o     = r_ds1;
  assign is_in_delayslot2_o     = r_ds2;
  assign mem_addr_o             = r_mem_addr;
  assign redirect_pc_o          = r_redirect_pc;
  assign redirect_valid_o       = w_redirect_valid;
  assign stall_o                = w_redirect_valid;
  assign dbg_state_o            = r_state;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed vector table, hand-written multi-cycle sequences and a
// randomized run against a priority-table reference model. Covers CP0_BYPASS_EN when defined.
module tb_exc_commit_ctrl;

  localparam int ADDR_W = 32;

  localparam logic [8:0] E_ADEL_IF  = 9'h001;
  localparam logic [8:0] E_ADEL_MEM = 9'h002;
  localparam logic [8:0] E_ADES     = 9'h004;
  localparam logic [8:0] E_SYS      = 9'h008;
  localparam logic [8:0] E_BP       = 9'h010;
  localparam logic [8:0] E_RI       = 9'h020;
  localparam logic [8:0] E_OV       = 9'h040;
  localparam logic [8:0] E_TR       = 9'h080;
  localparam logic [8:0] E_ERET     = 9'h100;

  localparam logic [31:0] EB   = 32'hBFC0_0200;
  localparam logic [31:0] VEC  = 32'hBFC0_0380;
  localparam logic [31:0] EPC  = 32'h8000_1000;
  localparam logic [31:0] M1   = 32'h1000_0010;
  localparam logic [31:0] M2   = 32'h2000_0020;
  localparam logic [31:0] PC1  = 32'h8000_0100;
  localparam logic [31:0] PC2  = 32'h8000_0204;

  // Priority order (high to low, after INT) as exception bit index and resulting code.
  localparam int PRIO_BIT  [9] = '{0, 5, 6, 7, 3, 4, 1, 2, 8};
  localparam int PRIO_CODE [9] = '{4, 10, 12, 13, 8, 9, 4, 5, 14};

  logic              clk = 1'b0;
  logic              rst;
  logic              slot1_valid_i, slot2_valid_i;
  logic [8:0]        slot1_exc_i, slot2_exc_i;
  logic [ADDR_W-1:0] inst1_addr_i, inst2_addr_i;
  logic              is_in_delayslot1_i, is_in_delayslot2_i;
  logic [ADDR_W-1:0] mem_addr1_i, mem_addr2_i;
  logic [31:0]       status_i, cause_i, epc_i, ebase_i;
  logic              redirect_ready_i;
`ifdef CP0_BYPASS_EN
  logic              cp0_we_i;
  logic [4:0]        cp0_waddr_i;
  logic [31:0]       cp0_wdata_i;
`endif
  logic              exception_flag_o;
  logic [4:0]        exception_type_o;
  logic              exception_first_inst_o;
  logic [ADDR_W-1:0] inst1_addr_o, inst2_addr_o;
  logic              is_in_delayslot1_o, is_in_delayslot2_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              flush_o, stall_o, redirect_valid_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              dbg_state_o;

  int checks   = 0;
  int failures = 0;

  exc_commit_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .slot1_valid_i(slot1_valid_i), .slot2_valid_i(slot2_valid_i),
    .slot1_exc_i(slot1_exc_i), .slot2_exc_i(slot2_exc_i),
    .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
    .is_in_delayslot1_i(is_in_delayslot1_i), .is_in_delayslot2_i(is_in_delayslot2_i),
    .mem_addr1_i(mem_addr1_i), .mem_addr2_i(mem_addr2_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
    .redirect_ready_i(redirect_ready_i),
`ifdef CP0_BYPASS_EN
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
`endif
    .exception_flag_o(exception_flag_o), .exception_type_o(exception_type_o),
    .exception_first_inst_o(exception_first_inst_o),
    .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
    .is_in_delayslot1_o(is_in_delayslot1_o), .is_in_delayslot2_o(is_in_delayslot2_o),
    .mem_addr_o(mem_addr_o), .flush_o(flush_o), .stall_o(stall_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v1;
    logic [8:0]  e1;
    logic        v2;
    logic [8:0]  e2;
    logic        ds2;
    logic [31:0] st;
    logic [31:0] ca;
    logic [31:0] eb;
    logic        flag;
    logic [4:0]  typ;
    logic        first;
    logic [31:0] mem;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    slot1_valid_i      = 1'b0;
    slot2_valid_i      = 1'b0;
    slot1_exc_i        = '0;
    slot2_exc_i        = '0;
    is_in_delayslot1_i = 1'b0;
    is_in_delayslot2_i = 1'b0;
`ifdef CP0_BYPASS_EN
    cp0_we_i    = 1'b0;
    cp0_waddr_i = '0;
    cp0_wdata_i = '0;
`endif
  endtask

  function automatic logic [8:0] rand_exc();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return '0;
    if (sel == 3) return 9'($urandom_range(0, 511));
    return 9'(1 << $urandom_range(0, 8));
  endfunction

  // Reference selection straight from the rules: INT on a valid slot 1, then slot 1 by priority
  // table, then slot 2 by the same table.
  function automatic void ref_pick(input logic v1, input logic v2, input logic [8:0] e1,
                                   input logic [8:0] e2, input logic [31:0] st,
                                   input logic [31:0] ca, output bit take, output bit first,
                                   output logic [4:0] code);
    bit intr;
    take  = 0;
    first = 0;
    code  = '0;
    intr  = st[0] && !st[1] && ((st[15:8] & ca[15:8]) != 0);
    if (v1 && intr) begin
      take = 1; first = 1; code = 5'd0;
      return;
    end
    if (v1) begin
      for (int k = 0; k < 9; k++) begin
        if (e1[PRIO_BIT[k]]) begin
          take = 1; first = 1; code = 5'(PRIO_CODE[k]);
          return;
        end
      end
    end
    if (v2) begin
      for (int k = 0; k < 9; k++) begin
        if (e2[PRIO_BIT[k]]) begin
          take = 1; first = 0; code = 5'(PRIO_CODE[k]);
          return;
        end
      end
    end
  endfunction

  initial begin
    bit          pend, pend_nxt, take, first;
    logic [4:0]  code;
    logic [4:0]  m_typ;
    bit          m_first, m_ds1, m_ds2;
    logic [31:0] m_a1, m_a2, m_mem, m_pc;

    // Reset
    rst = 1'b0;
    drive_idle();
    inst1_addr_i = PC1; inst2_addr_i = PC2;
    mem_addr1_i = M1; mem_addr2_i = M2;
    status_i = '0; cause_i = '0; epc_i = EPC; ebase_i = EB;
    redirect_ready_i = 1'b1;
    #12;
    check("rst_flag", exception_flag_o, 0);
    check("rst_type", exception_type_o, 0);
    check("rst_first", exception_first_inst_o, 0);
    check("rst_a1", inst1_addr_o, 0);
    check("rst_a2", inst2_addr_o, 0);
    check("rst_ds", {is_in_delayslot1_o, is_in_delayslot2_o}, 0);
    check("rst_mem", mem_addr_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_valid", redirect_valid_o, 0);
    check("rst_pc", redirect_pc_o, 0);
    check("rst_state", dbg_state_o, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Directed vectors: {v1,e1,v2,e2,ds2,status,cause,ebase} -> {flag,type,first,mem,pc}
    vecs.push_back('{1'b1, E_RI, 1'b0, 9'h0, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd10, 1'b1, M1, VEC});
    vecs.push_back('{1'b1, 9'h0, 1'b1, E_OV, 1'b1, 32'h0, 32'h0, EB, 1'b1, 5'd12, 1'b0, M2, VEC});
    vecs.push_back('{1'b1, 9'h0, 1'b1, E_SYS, 1'b0, 32'h401, 32'h400, EB, 1'b1, 5'd0, 1'b1, M1, VEC});
    vecs.push_back('{1'b0, E_SYS, 1'b1, E_BP, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd9, 1'b0, M2, VEC});
    vecs.push_back('{1'b1, E_ADEL_IF | E_RI, 1'b0, 9'h0, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd4, 1'b1, M1, VEC});
    vecs.push_back('{1'b1, E_ADES | E_ERET, 1'b1, E_SYS, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd5, 1'b1, M1, VEC});
    vecs.push_back('{1'b0, 9'h0, 1'b1, E_ADEL_MEM | E_ADES, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd4, 1'b0, M2, VEC});
    vecs.push_back('{1'b1, E_ERET, 1'b0, 9'h0, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd14, 1'b1, M1, EPC});
    vecs.push_back('{1'b1, 9'h0, 1'b1, 9'h0, 1'b0, 32'h0, 32'h0, EB, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 9'h0, 1'b1, E_TR, 1'b0, 32'h403, 32'h400, EB, 1'b1, 5'd13, 1'b0, M2, VEC});
    vecs.push_back('{1'b0, 9'h0, 1'b0, 9'h0, 1'b0, 32'h401, 32'h400, EB, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, E_SYS, 1'b0, 9'h0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FF00, 1'b1, 5'd8, 1'b1, M1, 32'h0000_0080});
    vecs.push_back('{1'b1, E_TR | E_OV, 1'b0, 9'h0, 1'b0, 32'h0, 32'h0, EB, 1'b1, 5'd12, 1'b1, M1, VEC});
    vecs.push_back('{1'b1, E_BP | E_SYS, 1'b1, E_RI, 1'b1, 32'h0, 32'h0, EB, 1'b1, 5'd8, 1'b1, M1, VEC});
    vecs.push_back('{1'b1, E_BP, 1'b0, 9'h0, 1'b0, 32'h400, 32'h400, EB, 1'b1, 5'd9, 1'b1, M1, VEC});
    vecs.push_back('{1'b1, E_ADEL_IF, 1'b1, E_SYS, 1'b0, 32'h8001, 32'h8000, EB, 1'b1, 5'd0, 1'b1, M1, VEC});

    foreach (vecs[i]) begin
      drive_idle();
      slot1_valid_i = vecs[i].v1; slot1_exc_i = vecs[i].e1;
      slot2_valid_i = vecs[i].v2; slot2_exc_i = vecs[i].e2;
      is_in_delayslot2_i = vecs[i].ds2;
      status_i = vecs[i].st; cause_i = vecs[i].ca; ebase_i = vecs[i].eb;
      epc_i = EPC; redirect_ready_i = 1'b1;
      tick();
      check($sformatf("v%0d_flag", i), exception_flag_o, vecs[i].flag);
      check($sformatf("v%0d_flush", i), flush_o, vecs[i].flag);
      check($sformatf("v%0d_valid", i), redirect_valid_o, vecs[i].flag);
      if (vecs[i].flag) begin
        check($sformatf("v%0d_type", i), exception_type_o, vecs[i].typ);
        check($sformatf("v%0d_first", i), exception_first_inst_o, vecs[i].first);
        check($sformatf("v%0d_mem", i), mem_addr_o, vecs[i].mem);
        check($sformatf("v%0d_pc", i), redirect_pc_o, vecs[i].pc);
        check($sformatf("v%0d_a1", i), inst1_addr_o, PC1);
        check($sformatf("v%0d_a2", i), inst2_addr_o, PC2);
        check($sformatf("v%0d_ds2", i), is_in_delayslot2_o, vecs[i].ds2);
      end
      drive_idle();
      status_i = '0; cause_i = '0;
      tick();
      check($sformatf("v%0d_done", i), redirect_valid_o, 0);
    end

    // ERET with ready held low for three cycles; a bp during the hold is ignored
    drive_idle();
    ebase_i = EB; epc_i = EPC;
    slot1_valid_i = 1'b1; slot1_exc_i = E_ERET; redirect_ready_i = 1'b0;
    tick();
    check("eret_flag", exception_flag_o, 1);
    check("eret_type", exception_type_o, 5'd14);
    slot1_exc_i = E_BP; epc_i = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("hold%0d_valid", c), redirect_valid_o, 1);
      check($sformatf("hold%0d_stall", c), stall_o, 1);
      check($sformatf("hold%0d_pc", c), redirect_pc_o, EPC);
      if (c != 0) begin
        check($sformatf("hold%0d_flag", c), exception_flag_o, 0);
        check($sformatf("hold%0d_flush", c), flush_o, 0);
      end
      if (c == 3) redirect_ready_i = 1'b1;
      tick();
    end
    check("hold_end_valid", redirect_valid_o, 0);
    check("hold_end_stall", stall_o, 0);
    check("hold_end_flag", exception_flag_o, 0);
    slot1_exc_i = E_SYS;
    tick();
    check("b2b_flag", exception_flag_o, 1);
    check("b2b_type", exception_type_o, 5'd8);
    check("b2b_pc", redirect_pc_o, VEC);
    drive_idle();
    tick();
    check("b2b_done", redirect_valid_o, 0);

    // Asynchronous reset in REDIRECT
    slot2_valid_i = 1'b1; slot2_exc_i = E_OV; redirect_ready_i = 1'b0;
    tick();
    check("arst_pre_flush", flush_o, 1);
    check("arst_pre_valid", redirect_valid_o, 1);
    drive_idle();
    #2 rst = 1'b0;
    #1;
    check("arst_valid", redirect_valid_o, 0);
    check("arst_stall", stall_o, 0);
    check("arst_flush", flush_o, 0);
    check("arst_flag", exception_flag_o, 0);
    check("arst_state", dbg_state_o, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("arst_post_valid", redirect_valid_o, 0);
    check("arst_post_state", dbg_state_o, 0);
    redirect_ready_i = 1'b1;

`ifdef CP0_BYPASS_EN
    drive_idle();
    epc_i = EPC;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h8000_2000;
    slot1_valid_i = 1'b1; slot1_exc_i = E_ERET;
    tick();
    check("byp_epc_flag", exception_flag_o, 1);
    check("byp_epc_pc", redirect_pc_o, 32'h8000_2000);
    drive_idle();
    tick();
    status_i = '0; cause_i = 32'h400;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wdata_i = 32'h401;
    slot1_valid_i = 1'b1;
    tick();
    check("byp_int_flag", exception_flag_o, 1);
    check("byp_int_type", exception_type_o, 5'd0);
    drive_idle();
    cause_i = '0;
    tick();
`endif

    // Randomized run against the reference model
    drive_idle();
    pend = 0;
    m_typ = '0; m_first = 0; m_ds1 = 0; m_ds2 = 0;
    m_a1 = '0; m_a2 = '0; m_mem = '0; m_pc = '0;
    for (int n = 0; n < 400; n++) begin
      slot1_valid_i = 1'($urandom_range(0, 1));
      slot2_valid_i = 1'($urandom_range(0, 1));
      slot1_exc_i = rand_exc();
      slot2_exc_i = rand_exc();
      inst1_addr_i = $urandom(); inst2_addr_i = $urandom();
      mem_addr1_i = $urandom(); mem_addr2_i = $urandom();
      is_in_delayslot1_i = 1'($urandom_range(0, 1));
      is_in_delayslot2_i = 1'($urandom_range(0, 1));
      status_i = {16'h0, 8'($urandom_range(0, 255)), 6'h0, 2'($urandom_range(0, 3))};
      cause_i = ($urandom_range(0, 3) == 0) ? {16'h0, 8'($urandom_range(0, 255)), 8'h0} : 32'h0;
      epc_i = $urandom(); ebase_i = $urandom();
      redirect_ready_i = ($urandom_range(0, 2) != 0);

      take = 0;
      if (!pend) ref_pick(slot1_valid_i, slot2_valid_i, slot1_exc_i, slot2_exc_i,
                          status_i, cause_i, take, first, code);
      pend_nxt = pend ? !redirect_ready_i : take;
      if (take) begin
        m_typ = code; m_first = first;
        m_a1 = inst1_addr_i; m_a2 = inst2_addr_i;
        m_ds1 = is_in_delayslot1_i; m_ds2 = is_in_delayslot2_i;
        m_mem = first ? mem_addr1_i : mem_addr2_i;
        m_pc = (code == 5'd14) ? epc_i : ebase_i + 32'h0000_0180;
      end
      tick();
      check("rnd_flag", exception_flag_o, take);
      check("rnd_flush", flush_o, take);
      check("rnd_valid", redirect_valid_o, pend_nxt);
      check("rnd_stall", stall_o, pend_nxt);
      if (take) begin
        check("rnd_type", exception_type_o, m_typ);
        check("rnd_first", exception_first_inst_o, m_first);
        check("rnd_a1", inst1_addr_o, m_a1);
        check("rnd_a2", inst2_addr_o, m_a2);
        check("rnd_ds", {is_in_delayslot1_o, is_in_delayslot2_o}, {m_ds1, m_ds2});
        check("rnd_mem", mem_addr_o, m_mem);
      end
      if (pend_nxt) check("rnd_pc", redirect_pc_o, m_pc);
      pend = pend_nxt;
    end

    drive_idle();
    redirect_ready_i = 1'b1;
    tick();
    tick();
    check("final_valid", redirect_valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
